alu_serial_unit: RTL
====================

// Module: alu_serial_unit
// PURPOSE
//  Multi-cycle, slice-serial 32-bit ALU behind a valid/ready request/response handshake.
//  It is the responder side of the ALU command interface: it accepts {operand_a, operand_b, command}
//  and returns {result, carryout, zero, overflow}.
//  It processes SLICE bits per cycle, so the Lab datapath shares one narrow adder across cycles.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of SLICE
//  SLICE  4   bits processed per EXEC cycle; N = WIDTH/SLICE cycles per op (default 8)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      unit can accept a request (high only in IDLE)
//  operand_a  in   WIDTH  operand A, two's complement
//  operand_b  in   WIDTH  operand B, two's complement
//  command    in   3      ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
//  rsp_valid  out  1      response valid; held until taken
//  rsp_ready  in   1      consumer accepts response
//  result     out  WIDTH  registered result
//  carryout   out  1      registered carry out of MSB (ADD/SUB only, else 0)
//  zero       out  1      registered; 1 iff result == 0 (all commands)
//  overflow   out  1      registered signed overflow (ADD/SUB only, else 0)
//  busy       out  1      high in EXEC or DONE
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; rsp_valid=0; result=0; carryout=0; overflow=0; zero=0; busy=0.
//   - Any in-flight op is discarded; no response is ever produced for it.
//  FSM: IDLE -> EXEC -> DONE -> IDLE.
//  IDLE:
//   - req_ready=1.
//   - On req_valid, capture A, B' and cmd; go to EXEC; slice counter=0.
//   - B' = ~B for SUB/SLT, else B. Initial carry = 1 for SUB/SLT, else 0.
//  EXEC:
//   - Each cycle, slice k = bits [k*SLICE +: SLICE] is computed and written into the result shift register.
//   - Carry is registered between slices.
//   - After slice N-1, go to DONE and assert rsp_valid.
//   - Latency: rsp_valid rises N cycles after the accepting edge.
//  Finalise (at the last EXEC edge):
//   - c31 = carry into MSB, c32 = carry out of MSB.
//   - ADD/SUB: carryout=c32; overflow=c31^c32.
//   - SLT: result={WIDTH-1 zeros, diff[MSB]^ovf}; carryout=0; overflow=0.
//   - Logic ops: bitwise per slice; carryout=0; overflow=0.
//   - zero is computed on the final result.
//   - Arithmetic is modulo 2^WIDTH.
//  DONE:
//   - rsp_valid=1; result and flags held stable while rsp_ready=0.
//   - On rsp_ready, go to IDLE with rsp_valid=0.
//   - Throughput: one op per N+2 cycles minimum.
//  Handshake rules:
//   - A request while not in IDLE is ignored (req_ready=0); the requester must hold it.
//   - Inputs are sampled only at acceptance; changes to inputs during EXEC have no effect.
//   - Outputs keep the last response after DONE -> IDLE until the next completion overwrites them.
// STRUCTURE
//  alu_pkg:
//   - command localparams (ADD..OR, 3-bit).
//   - FSM state encoding (IDLE=0, EXEC=1, DONE=2).
//  alu_slice:
//   - combinational SLICE-bit unit: inputs a, b', cin, cmd.
//   - outputs y, cout, c_into_msb (carry into the slice's top bit, used for overflow).
//  alu_serial_unit:
//   - FSM, slice counter ($clog2(N) bits), operand shift registers, carry reg, flag regs.
// TESTING
//  ADD 2+1 -> rsp_valid after 8 cycles; result=3, cout=0, ovf=0, zero=0.
//  SUB 4-2 -> result=2, cout=1, ovf=0.
//  SUB 5-5 -> result=0, zero=1, cout=1.
//  ADD -5+-7 -> result=-12 (0xFFFFFFF4), cout=1, ovf=0.
//  ADD 0x7FFFFFFF+1 -> result=0x80000000, ovf=1, cout=0.
//  SLT: 4,2 -> 0; SLT -3,2 -> 1; SLT 0x80000000,1 -> 1. All with cout=0, ovf=0.
//  Logic ops on A=0xF0F0F0F0, B=0xFF00FF00:
//   - XOR -> 0x0FF00FF0; AND -> 0xF000F000; NAND -> 0x0FFF0FFF;
//   - NOR -> 0x000F000F; OR -> 0xFFF0FFF0; ovf=cout=0.
//  Backpressure and input sampling:
//   - Hold rsp_ready=0 for 5 cycles -> result and flags stable, req_ready=0.
//   - Change operand_a mid-EXEC -> result unaffected.
//  Reset mid-op:
//   - Assert reset at EXEC slice 3 -> immediately rsp_valid=0, outputs=0, req_ready=1.
//   - A following ADD 1+1 -> result=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the slice-serial ALU: command codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SUB and SLT run through the adder as A + ~B + 1.
  function automatic logic is_sub_like(input logic [2:0] cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU unit; b is already conditionally inverted by the caller.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       cmd,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_into_msb
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] sum;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout       = c[SLICE];
    c_into_msb = c[SLICE-1];
  end

  always_comb begin
    y = sum;
    case (cmd)
      CMD_XOR:  y = a ^ b;
      CMD_AND:  y = a & b;
      CMD_NAND: y = ~(a & b);
      CMD_NOR:  y = ~(a | b);
      CMD_OR:   y = a | b;
      default:  y = sum;
    endcase
  end

endmodule

// File: rtl/alu_serial_unit.sv
// Slice-serial ALU: one SLICE-bit slice per EXEC cycle, valid/ready request and response.
module alu_serial_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       command,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, acc_sr;
  logic [2:0]       cmd_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] s_y;
  logic             s_cout, s_cmsb;
  logic             accept, last;

  logic [WIDTH-1:0] full_res, fin_res;
  logic             fin_c, fin_o;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a          (a_sr[SLICE-1:0]),
    .b          (b_sr[SLICE-1:0]),
    .cin        (carry_r),
    .cmd        (cmd_r),
    .y          (s_y),
    .cout       (s_cout),
    .c_into_msb (s_cmsb)
  );

  assign accept   = (state == ST_IDLE) && req_valid;
  assign last     = (state == ST_EXEC) && (cnt == CW'(N - 1));
  // Result assembles LSB-first: each new slice enters at the top and shifts down.
  assign full_res = {s_y, acc_sr[WIDTH-1:SLICE]};

  always_comb begin
    fin_res = full_res;
    fin_c   = 1'b0;
    fin_o   = 1'b0;
    case (cmd_r)
      CMD_ADD, CMD_SUB: begin
        fin_c = s_cout;
        fin_o = s_cout ^ s_cmsb;
      end
      CMD_SLT: begin
        fin_res    = '0;
        fin_res[0] = full_res[WIDTH-1] ^ (s_cout ^ s_cmsb);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      acc_sr  <= '0;
      cmd_r   <= CMD_ADD;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sr    <= operand_a;
      b_sr    <= is_sub_like(command) ? ~operand_b : operand_b;
      cmd_r   <= command;
      carry_r <= is_sub_like(command);
      cnt     <= '0;
    end else if (state == ST_EXEC) begin
      a_sr    <= a_sr >> SLICE;
      b_sr    <= b_sr >> SLICE;
      acc_sr  <= full_res;
      carry_r <= s_cout;
      cnt     <= cnt + 1'b1;
    end
  end

  // Visible outputs only change at completion so the last response persists in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (last) begin
      result   <= fin_res;
      carryout <= fin_c;
      overflow <= fin_o;
      zero     <= (fin_res == '0);
    end
  end

endmodule
